datapath_seq_ctrl: RTL

//  Parametrised multi-cycle datapath: register file, data memory and ALU driven by one FSM.

---
 rtl/datapath_seq_ctrl_pkg.sv | 36 +++
 rtl/datapath_seq_ctrl_if.sv | 49 ++++
 rtl/datapath_seq_ctrl_alu.sv | 47 ++++
 rtl/datapath_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_ctrl_pkg.sv
// Purpose : shared definitions for the multi-cycle datapath (op codes, FSM
//           state encoding, op legality helpers).
// Contents: OP_W, OP_NOP..OP_LOAD, state_t, op_is_legal(), op_is_alu().
// Config  : none here; the optional flag outputs are controlled by
//           DATAPATH_FLAGS_EN in the interface, ALU and top files.
package datapath_pkg;

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_NOP   = 7'd0;
    localparam logic [OP_W-1:0] OP_STORE = 7'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 7'd2;
    localparam logic [OP_W-1:0] OP_SUB   = 7'd3;
    localparam logic [OP_W-1:0] OP_AND   = 7'd4;
    localparam logic [OP_W-1:0] OP_OR    = 7'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 7'd6;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Codes 0..7 are defined; everything above is illegal.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LOAD);
    endfunction

    function automatic logic op_is_alu(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/datapath_seq_ctrl_if.sv
// Purpose : instruction/result bundle between the sequencer (master) and the
//           datapath (slave).
// Signals : start, op_code, rs1, rs2, rd, rd_in  (master -> slave)
//           busy, done, error, result            (slave -> master)
//           flag_z, flag_n, flag_v               (slave -> master, only when
//                                                 DATAPATH_FLAGS_EN is defined)
interface datapath_seq_ctrl_if #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned DM_DEPTH = 32
);
    localparam int unsigned RF_AW = $clog2(RF_DEPTH);
    localparam int unsigned DM_AW = $clog2(DM_DEPTH);

    logic                          start;
    logic [datapath_pkg::OP_W-1:0] op_code;
    logic [RF_AW-1:0]              rs1;
    logic [RF_AW-1:0]              rs2;
    logic [DM_AW-1:0]              rd;
    logic [WORDSIZE-1:0]           rd_in;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [WORDSIZE-1:0]           result;
`ifdef DATAPATH_FLAGS_EN
    logic                          flag_z;
    logic                          flag_n;
    logic                          flag_v;

    modport master (
        output start, op_code, rs1, rs2, rd, rd_in,
        input  busy, done, error, result, flag_z, flag_n, flag_v
    );
    modport slave (
        input  start, op_code, rs1, rs2, rd, rd_in,
        output busy, done, error, result, flag_z, flag_n, flag_v
    );
`else
    modport master (
        output start, op_code, rs1, rs2, rd, rd_in,
        input  busy, done, error, result
    );
    modport slave (
        input  start, op_code, rs1, rs2, rd, rd_in,
        output busy, done, error, result
    );
`endif

endinterface

// File: rtl/datapath_seq_ctrl_alu.sv
// Purpose : combinational ALU for the datapath (ADD/SUB/AND/OR/XOR, wrapping
//           two's complement, no carry out).
// Ports   : a, b  in  WORDSIZE  operands (SUB computes a - b)
//           op    in  OP_W      op code; non-ALU codes give y = 0
//           y     out WORDSIZE  result
//           v     out 1         signed overflow for ADD/SUB, else 0
//                               (only when DATAPATH_FLAGS_EN is defined)
module alu_unit
    import datapath_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    input  logic [OP_W-1:0]     op,
    output logic [WORDSIZE-1:0] y
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic                v
`endif
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

`ifdef DATAPATH_FLAGS_EN
    // Overflow: result sign disagrees with a where the operand signs make it impossible.
    always_comb begin
        v = 1'b0;
        if (op == OP_ADD) begin
            v = (a[WORDSIZE-1] == b[WORDSIZE-1]) && (y[WORDSIZE-1] != a[WORDSIZE-1]);
        end else if (op == OP_SUB) begin
            v = (a[WORDSIZE-1] != b[WORDSIZE-1]) && (y[WORDSIZE-1] != a[WORDSIZE-1]);
        end
    end
`endif

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Purpose : multi-cycle datapath (register file, data memory, ALU) sequenced
//           by a five-state FSM; one instruction per start handshake.
// Ports   : clk   in  single clock, posedge
//           rst   in  synchronous active-high reset
//           bus   slave modport of datapath_seq_ctrl_if (start/op/operands in,
//                 busy/done/error/result out)
// Config  : DATAPATH_FLAGS_EN adds flag_z/flag_n/flag_v, registered at DONE.
// Timing  : start sampled at edge N, done visible after edge N+4; the done
//           cycle is spent in IDLE, so a new start can be taken at the edge
//           closing the done cycle (one op every 5 cycles).
module datapath_seq_ctrl
    import datapath_pkg::*;
#(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned DM_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    datapath_seq_ctrl_if.slave  bus
);

    localparam int unsigned RF_AW = $clog2(RF_DEPTH);
    localparam int unsigned DM_AW = $clog2(DM_DEPTH);

    // Storage arrays; contents survive reset.
    logic [WORDSIZE-1:0] rf [RF_DEPTH];
    logic [WORDSIZE-1:0] dm [DM_DEPTH];

    state_t              state;
    logic [OP_W-1:0]     op_q;
    logic [RF_AW-1:0]    rs1_q;
    logic [RF_AW-1:0]    rs2_q;
    logic [DM_AW-1:0]    rd_q;
    logic [WORDSIZE-1:0] din_q;
    logic [WORDSIZE-1:0] op_a;
    logic [WORDSIZE-1:0] op_b;
    logic [WORDSIZE-1:0] mem_q;
    logic [WORDSIZE-1:0] res_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [WORDSIZE-1:0] result_q;
    logic [WORDSIZE-1:0] alu_y;
`ifdef DATAPATH_FLAGS_EN
    logic                alu_v;
    logic                v_q;
    logic                flag_z_q;
    logic                flag_n_q;
    logic                flag_v_q;
`endif

    alu_unit #(
        .WORDSIZE (WORDSIZE)
    ) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (op_q),
        .y  (alu_y)
`ifdef DATAPATH_FLAGS_EN
        ,
        .v  (alu_v)
`endif
    );

    // Sequencer: latches the instruction, then steps READ/EXEC/WRITE/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            din_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            mem_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
`ifdef DATAPATH_FLAGS_EN
            v_q      <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= bus.start;
                    if (bus.start) begin
                        op_q  <= bus.op_code;
                        rs1_q <= bus.rs1;
                        rs2_q <= bus.rs2;
                        rd_q  <= bus.rd;
                        din_q <= bus.rd_in;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    op_a  <= rf[rs1_q];
                    op_b  <= rf[rs2_q];
                    mem_q <= dm[DM_AW'(rs1_q)];
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q == OP_STORE) begin
                        res_q <= din_q;
                    end else if (op_q == OP_LOAD) begin
                        res_q <= mem_q;
                    end else if (op_is_alu(op_q)) begin
                        res_q <= alu_y;
                    end else begin
                        res_q <= '0;
                    end
`ifdef DATAPATH_FLAGS_EN
                    v_q   <= alu_v;
`endif
                    state <= ST_EXEC == ST_EXEC ? ST_WRITE : ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done_q   <= 1'b1;
                    error_q  <= ~op_is_legal(op_q);
                    result_q <= res_q;
`ifdef DATAPATH_FLAGS_EN
                    flag_z_q <= (res_q == '0);
                    flag_n_q <= res_q[WORDSIZE-1];
                    flag_v_q <= v_q;
`endif
                    state    <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Single architectural write per op, in WRITE; a reset in that cycle suppresses it.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_WRITE)) begin
            case (op_q)
                OP_STORE: begin
                    rf[rs1_q] <= res_q;
                    dm[rd_q]  <= res_q;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    dm[rd_q] <= res_q;
                end
                OP_LOAD: begin
                    rf[RF_AW'(rd_q)] <= res_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;
    assign bus.result = result_q;
`ifdef DATAPATH_FLAGS_EN
    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_v = flag_v_q;
`endif

endmodule
